// File: rtl/dispatch_queue_pkg.sv
// Shared opcode encodings, unit classes and operand-form types
// for the in-order dispatch queue.
package dispatch_queue_pkg;

  localparam int TAG_W_DEF = 5;
  localparam int OP_W_DEF  = 6;

  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h03;
  localparam logic [5:0] OP_ORI   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h06;
  localparam logic [5:0] OP_BEQ   = 6'h07;
  localparam logic [5:0] OP_BNE   = 6'h08;
  localparam logic [5:0] OP_JAL   = 6'h09;
  localparam logic [5:0] OP_JALR  = 6'h0a;
  localparam logic [5:0] OP_LUI   = 6'h0b;
  localparam logic [5:0] OP_AUIPC = 6'h0c;

  typedef enum logic [1:0] {
    UNIT_DROP,
    UNIT_RS,
    UNIT_LSB
  } unit_e;

  typedef enum logic [1:0] {
    SRC1_RF,
    SRC1_PC,
    SRC1_ZERO
  } src1_e;

  typedef enum logic [1:0] {
    SRC2_RF,
    SRC2_IMM,
    SRC2_FOUR
  } src2_e;

  typedef struct packed {
    unit_e unit;
    src1_e src1;
    src2_e src2;
    logic  wr_rd;
  } opcls_t;

  function automatic opcls_t mk_cls(
    input unit_e u,
    input src1_e s1,
    input src2_e s2,
    input logic  w
  );
    opcls_t c;
    c.unit  = u;
    c.src1  = s1;
    c.src2  = s2;
    c.wr_rd = w;
    return c;
  endfunction

endpackage

// File: rtl/dispatch_queue_op_classify.sv
// Head-of-queue decode: target unit, operand sources and
// whether the instruction renames its destination register.
module op_classify
  import dispatch_queue_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op_i,
  output opcls_t          cls_o
);

  always_comb begin
    cls_o = mk_cls(UNIT_DROP, SRC1_RF, SRC2_RF, 1'b0);
    unique case (1'b1)
      (op_i == OP_W'(OP_ADD)),
      (op_i == OP_W'(OP_SUB)):
        cls_o = mk_cls(UNIT_RS, SRC1_RF, SRC2_RF, 1'b1);
      (op_i == OP_W'(OP_ADDI)),
      (op_i == OP_W'(OP_ORI)),
      (op_i == OP_W'(OP_JALR)):
        cls_o = mk_cls(UNIT_RS, SRC1_RF, SRC2_IMM, 1'b1);
      (op_i == OP_W'(OP_BEQ)),
      (op_i == OP_W'(OP_BNE)):
        cls_o = mk_cls(UNIT_RS, SRC1_RF, SRC2_RF, 1'b0);
      (op_i == OP_W'(OP_JAL)):
        cls_o = mk_cls(UNIT_RS, SRC1_PC, SRC2_FOUR, 1'b1);
      (op_i == OP_W'(OP_LUI)):
        cls_o = mk_cls(UNIT_RS, SRC1_ZERO, SRC2_IMM, 1'b1);
      (op_i == OP_W'(OP_AUIPC)):
        cls_o = mk_cls(UNIT_RS, SRC1_PC, SRC2_IMM, 1'b1);
      (op_i == OP_W'(OP_LW)):
        cls_o = mk_cls(UNIT_LSB, SRC1_RF, SRC2_IMM, 1'b1);
      (op_i == OP_W'(OP_SW)):
        cls_o = mk_cls(UNIT_LSB, SRC1_RF, SRC2_RF, 1'b0);
      default: ;
    endcase
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order decoded-instruction queue feeding the ROB, RS and
// LSB, with register renaming and CDB operand snooping.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [OP_W-1:0]        id_op,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rd,
  input  logic [31:0]            id_imm,
  input  logic [31:0]            id_pc,
  output logic [4:0]             rf_rs1_addr,
  output logic [4:0]             rf_rs2_addr,
  input  logic                   rf_busy1,
  input  logic                   rf_busy2,
  input  logic [TAG_W-1:0]       rf_tag1,
  input  logic [TAG_W-1:0]       rf_tag2,
  input  logic [31:0]            rf_data1,
  input  logic [31:0]            rf_data2,
  output logic                   rf_rename_en,
  output logic [4:0]             rf_rename_addr,
  output logic [TAG_W-1:0]       rf_rename_tag,
  input  logic                   rob_ready,
  input  logic [TAG_W-1:0]       rob_free_tag,
  output logic                   rob_valid,
  output logic [OP_W-1:0]        rob_op,
  output logic [31:0]            rob_pc,
  output logic [31:0]            rob_imm,
  output logic [4:0]             rob_rd,
  input  logic [NUM_CDB-1:0]     cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]  cdb_data,
  input  logic                   rs_ready,
  input  logic                   lsb_ready,
  output logic                   rs_valid,
  output logic                   lsb_valid,
  output logic [OP_W-1:0]        ex_op,
  output logic                   ex_busy1,
  output logic                   ex_busy2,
  output logic [TAG_W-1:0]       ex_tag1,
  output logic [TAG_W-1:0]       ex_tag2,
  output logic [31:0]            ex_data1,
  output logic [31:0]            ex_data2,
  output logic [31:0]            ex_imm,
  output logic [TAG_W-1:0]       ex_dest
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [31:0]     pc;
  } ent_t;

  typedef struct packed {
    logic             rob_v;
    logic             rs_v;
    logic             lsb_v;
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [4:0]       rd;
    logic             busy1;
    logic             busy2;
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [TAG_W-1:0] dest;
  } out_t;

  ent_t             mem_q [DEPTH];
  ent_t             mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  out_t             out_q, out_d;

  ent_t             head;
  opcls_t           cls;
  logic             head_v, unit_rdy, go;
  logic             drop, disp, enq;
  logic             b1, b2, hit1, hit2;
  logic [TAG_W-1:0] t1, t2;
  logic [31:0]      d1, d2;

  assign head   = mem_q[rd_ptr_q];
  assign head_v = (cnt_q != '0);

  op_classify #(.OP_W(OP_W)) u_cls (
    .op_i  (head.op),
    .cls_o (cls)
  );

  assign unit_rdy = (cls.unit == UNIT_RS) ? rs_ready : lsb_ready;
  assign go       = head_v && rdy_in && !clear;
  // Unknown opcodes leave the queue without touching ROB or units.
  assign drop     = go && (cls.unit == UNIT_DROP);
  assign disp     = go && (cls.unit != UNIT_DROP)
                    && rob_ready && unit_rdy;
  assign id_ready = (cnt_q < CW'(DEPTH));
  assign enq      = id_valid && id_ready && rdy_in && !clear;

  assign rf_rs1_addr    = head.rs1;
  assign rf_rs2_addr    = head.rs2;
  assign rf_rename_en   = disp && cls.wr_rd && (head.rd != 5'd0);
  assign rf_rename_addr = head.rd;
  assign rf_rename_tag  = rob_free_tag;

  always_comb begin
    b1 = rf_busy1;
    t1 = rf_tag1;
    d1 = rf_data1;
    b2 = rf_busy2;
    t2 = rf_tag2;
    d2 = rf_data2;
    unique case (cls.src1)
      SRC1_PC:   begin b1 = 1'b0; d1 = head.pc; end
      SRC1_ZERO: begin b1 = 1'b0; d1 = '0;      end
      default: ;
    endcase
    unique case (cls.src2)
      SRC2_IMM:  begin b2 = 1'b0; d2 = head.imm; end
      SRC2_FOUR: begin b2 = 1'b0; d2 = 32'd4;    end
      default: ;
    endcase
    hit1 = 1'b0;
    hit2 = 1'b0;
    // Scan high to low so the lowest matching channel wins.
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (b1 && cdb_valid[i]
          && cdb_tag[i*TAG_W +: TAG_W] == t1) begin
        hit1 = 1'b1;
        d1   = cdb_data[i*32 +: 32];
      end
      if (b2 && cdb_valid[i]
          && cdb_tag[i*TAG_W +: TAG_W] == t2) begin
        hit2 = 1'b1;
        d2   = cdb_data[i*32 +: 32];
      end
    end
    if (hit1) b1 = 1'b0;
    if (hit2) b2 = 1'b0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{op: id_op, rs1: id_rs1,
                          rs2: id_rs2, rd: id_rd,
                          imm: id_imm, pc: id_pc};
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (drop || disp) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(enq) - CW'(drop || disp);
    end
  end

  always_comb begin
    out_d       = out_q;
    out_d.rob_v = disp;
    out_d.rs_v  = disp && (cls.unit == UNIT_RS);
    out_d.lsb_v = disp && (cls.unit == UNIT_LSB);
    if (disp) begin
      out_d.op    = head.op;
      out_d.pc    = head.pc;
      out_d.imm   = head.imm;
      out_d.rd    = head.rd;
      out_d.busy1 = b1;
      out_d.busy2 = b2;
      out_d.tag1  = t1;
      out_d.tag2  = t2;
      out_d.data1 = d1;
      out_d.data2 = d2;
      out_d.dest  = rob_free_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign rob_valid = out_q.rob_v;
  assign rob_op    = out_q.op;
  assign rob_pc    = out_q.pc;
  assign rob_imm   = out_q.imm;
  assign rob_rd    = out_q.rd;
  assign rs_valid  = out_q.rs_v;
  assign lsb_valid = out_q.lsb_v;
  assign ex_op     = out_q.op;
  assign ex_busy1  = out_q.busy1;
  assign ex_busy2  = out_q.busy2;
  assign ex_tag1   = out_q.tag1;
  assign ex_tag2   = out_q.tag2;
  assign ex_data1  = out_q.data1;
  assign ex_data2  = out_q.data2;
  assign ex_imm    = out_q.imm;
  assign ex_dest   = out_q.dest;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: latency, ordering, CDB
// snoop, stalls, clear, rdy_in hold and async reset.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic        clk_in, rst_in, rdy_in, clear;
  logic        id_valid, id_ready;
  logic [5:0]  id_op;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic        rf_busy1, rf_busy2;
  logic [4:0]  rf_tag1, rf_tag2;
  logic [31:0] rf_data1, rf_data2;
  logic        rf_rename_en;
  logic [4:0]  rf_rename_addr, rf_rename_tag;
  logic        rob_ready;
  logic [4:0]  rob_free_tag;
  logic        rob_valid;
  logic [5:0]  rob_op;
  logic [31:0] rob_pc, rob_imm;
  logic [4:0]  rob_rd;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        rs_ready, lsb_ready, rs_valid, lsb_valid;
  logic [5:0]  ex_op;
  logic        ex_busy1, ex_busy2;
  logic [4:0]  ex_tag1, ex_tag2, ex_dest;
  logic [31:0] ex_data1, ex_data2, ex_imm;

  int nvec = 0;
  int nbad = 0;

  dispatch_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear(clear), .id_valid(id_valid), .id_ready(id_ready),
    .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_pc(id_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
    .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_rename_en(rf_rename_en),
    .rf_rename_addr(rf_rename_addr),
    .rf_rename_tag(rf_rename_tag),
    .rob_ready(rob_ready), .rob_free_tag(rob_free_tag),
    .rob_valid(rob_valid), .rob_op(rob_op), .rob_pc(rob_pc),
    .rob_imm(rob_imm), .rob_rd(rob_rd),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .rs_ready(rs_ready),
    .lsb_ready(lsb_ready), .rs_valid(rs_valid),
    .lsb_valid(lsb_valid), .ex_op(ex_op),
    .ex_busy1(ex_busy1), .ex_busy2(ex_busy2),
    .ex_tag1(ex_tag1), .ex_tag2(ex_tag2),
    .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_imm(ex_imm), .ex_dest(ex_dest)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] imm, input logic [31:0] pc);
    id_valid = 1'b1;
    id_op    = op;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    id_imm   = imm;
    id_pc    = pc;
    tick();
    id_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0;
    id_rd = '0; id_imm = '0; id_pc = '0;
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = '0; rf_tag2 = '0;
    rf_data1 = '0; rf_data2 = '0;
    rob_ready = 1'b1; rob_free_tag = 5'd7;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    rs_ready = 1'b1; lsb_ready = 1'b1;

    repeat (2) tick();
    chk("rst_rob_valid", rob_valid, 0);
    chk("rst_rs_valid", rs_valid, 0);
    chk("rst_lsb_valid", lsb_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_ex_data1", ex_data1, 0);
    rst_in = 1'b1;
    tick();

    // addi x1,x0,5 on an empty queue
    push(OP_ADDI, 0, 0, 1, 32'd5, 32'h100);
    chk("addi_rename_en", rf_rename_en, 1);
    chk("addi_rename_addr", rf_rename_addr, 1);
    chk("addi_rename_tag", rf_rename_tag, 7);
    chk("addi_early_valid", rs_valid, 0);
    tick();
    chk("addi_rs_valid", rs_valid, 1);
    chk("addi_rob_valid", rob_valid, 1);
    chk("addi_lsb_valid", lsb_valid, 0);
    chk("addi_data2", ex_data2, 5);
    chk("addi_busy2", ex_busy2, 0);
    chk("addi_dest", ex_dest, 7);
    chk("addi_rob_rd", rob_rd, 1);
    chk("addi_rob_pc", rob_pc, 32'h100);
    tick();
    chk("addi_pulse", rs_valid, 0);

    // fill to full with RS stalled, then drain in order
    rs_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(OP_ADDI, 0, 0, 5'(i + 1), 32'(11 + i), 0);
      chk("fill_id_ready", id_ready, (i < 3) ? 1 : 0);
    end
    push(OP_ADDI, 0, 0, 5, 32'd99, 0);
    chk("full_stall_valid", rs_valid, 0);
    rs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_valid", rs_valid, 1);
      chk("drain_imm", ex_imm, 32'(11 + i));
    end
    tick();
    chk("drain_empty", rs_valid, 0);

    // CDB snoop on busy rs1, then duplicate-tag priority
    rf_busy1 = 1'b1; rf_tag1 = 5'd3; rf_data2 = 32'h22;
    cdb_valid = 2'b11;
    cdb_tag = {5'd3, 5'd9};
    cdb_data = {32'h77, 32'h11};
    push(OP_ADD, 4, 5, 2, 0, 0);
    tick();
    chk("cdb_busy1", ex_busy1, 0);
    chk("cdb_data1", ex_data1, 32'h77);
    chk("cdb_data2", ex_data2, 32'h22);
    cdb_tag = {5'd3, 5'd3};
    cdb_data = {32'h77, 32'hAA};
    rf_busy2 = 1'b1; rf_tag2 = 5'd6;
    push(OP_ADD, 4, 5, 2, 0, 0);
    tick();
    chk("cdb_prio_data1", ex_data1, 32'hAA);
    chk("cdb_nohit_busy2", ex_busy2, 1);
    chk("cdb_nohit_tag2", ex_tag2, 6);
    rf_busy1 = 1'b0; rf_busy2 = 1'b0; cdb_valid = '0;

    // store stalled on LSB blocks the ALU op behind it
    lsb_ready = 1'b0;
    push(OP_SW, 1, 2, 0, 32'd8, 0);
    push(OP_ADD, 1, 2, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("sw_stall_lsb", lsb_valid, 0);
      chk("sw_stall_rs", rs_valid, 0);
      chk("sw_stall_rename", rf_rename_en, 0);
      tick();
    end
    lsb_ready = 1'b1;
    #1;
    chk("sw_no_rename", rf_rename_en, 0);
    tick();
    chk("sw_lsb_valid", lsb_valid, 1);
    chk("sw_rs_valid", rs_valid, 0);
    chk("sw_imm", ex_imm, 8);
    chk("add_rename_en", rf_rename_en, 1);
    chk("add_rename_addr", rf_rename_addr, 3);
    tick();
    chk("add_rs_valid", rs_valid, 1);

    // clear with 3 queued plus a concurrent push
    rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(OP_ADDI, 0, 0, 1, 32'(i), 0);
    clear = 1'b1; rs_ready = 1'b1;
    id_valid = 1'b1; id_op = OP_ADDI; id_rd = 9; id_imm = 99;
    #1;
    chk("clr_rename", rf_rename_en, 0);
    tick();
    clear = 1'b0; id_valid = 1'b0;
    chk("clr_rs_valid", rs_valid, 0);
    chk("clr_rob_valid", rob_valid, 0);
    chk("clr_id_ready", id_ready, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("clr_empty", rs_valid, 0);
    end
    rs_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(OP_ADDI, 0, 0, 1, 0, 0);
      chk("clr_refill_ready", id_ready, (i < 3) ? 1 : 0);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // rdy_in low holds the queue and blocks enqueue
    push(OP_ADDI, 0, 0, 4, 32'd42, 0);
    rdy_in = 1'b0; rs_ready = 1'b1;
    #1;
    chk("hold_rename", rf_rename_en, 0);
    tick();
    chk("hold_valid", rs_valid, 0);
    push(OP_ADDI, 0, 0, 4, 32'd77, 0);
    chk("hold_valid2", rs_valid, 0);
    rdy_in = 1'b1;
    #1;
    chk("resume_rename", rf_rename_en, 1);
    tick();
    chk("resume_valid", rs_valid, 1);
    chk("resume_imm", ex_imm, 42);
    tick();
    chk("resume_no_extra", rs_valid, 0);

    // operand forms and a dropped unknown opcode
    rf_busy1 = 1'b1; rf_tag1 = 5'd2; rf_data1 = 32'hdead;
    rs_ready = 1'b0;
    push(OP_JAL, 0, 0, 1, 0, 32'h200);
    push(6'h3f, 0, 0, 1, 0, 0);
    push(OP_LUI, 0, 0, 2, 32'h12345000, 0);
    push(OP_AUIPC, 0, 0, 3, 32'h1000, 32'h300);
    rs_ready = 1'b1;
    tick();
    chk("jal_valid", rs_valid, 1);
    chk("jal_busy1", ex_busy1, 0);
    chk("jal_data1", ex_data1, 32'h200);
    chk("jal_data2", ex_data2, 4);
    tick();
    chk("drop_rs", rs_valid, 0);
    chk("drop_rob", rob_valid, 0);
    tick();
    chk("lui_valid", rs_valid, 1);
    chk("lui_data1", ex_data1, 0);
    chk("lui_data2", ex_data2, 32'h12345000);
    tick();
    chk("auipc_busy1", ex_busy1, 0);
    chk("auipc_data1", ex_data1, 32'h300);
    chk("auipc_data2", ex_data2, 32'h1000);
    rf_busy1 = 1'b0; rf_data1 = '0;
    tick();

    // async reset: in-flight head discarded, valids drop at once
    push(OP_ADDI, 0, 0, 1, 32'd5, 0);
    tick();
    chk("pre_rst_valid", rs_valid, 1);
    push(OP_ADDI, 0, 0, 1, 32'd6, 0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_rs_valid", rs_valid, 0);
    chk("arst_rob_valid", rob_valid, 0);
    chk("arst_data2", ex_data2, 0);
    chk("arst_id_ready", id_ready, 1);
    tick();
    rst_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_rst_idle", rs_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-003 SHALL have parameter NUM_CDB, default 2, count of CDB snoop channels (1..4).
REQ-004 SHALL have parameter OP_W, default 6, opcode width.
REQ-005 SHALL have ports: clk_in in 1 clock; rst_in in 1 reset, asynchronous, active-low; rdy_in in 1 global enable; clear in 1 flush.
REQ-006 SHALL have ID ports: id_valid in 1; id_ready out 1; id_op in OP_W; id_rs1/id_rs2/id_rd in 5; id_imm in 32; id_pc in 32.
REQ-007 SHALL have regfile ports: rf_rs1_addr/rf_rs2_addr out 5; rf_busy1/rf_busy2 in 1; rf_tag1/rf_tag2 in TAG_W; rf_data1/rf_data2 in 32; rf_rename_en out 1; rf_rename_addr out 5; rf_rename_tag out TAG_W.
REQ-008 SHALL have ROB ports: rob_ready in 1 (not full); rob_free_tag in TAG_W; rob_valid out 1; rob_op out OP_W; rob_pc/rob_imm out 32; rob_rd out 5.
REQ-009 SHALL have CDB ports: cdb_valid in NUM_CDB; cdb_tag in NUM_CDB*TAG_W; cdb_data in NUM_CDB*32.
REQ-010 SHALL have RS/LSB ports: rs_ready/lsb_ready in 1; rs_valid/lsb_valid out 1; ex_op out OP_W; ex_busy1/ex_busy2 out 1; ex_tag1/ex_tag2 out TAG_W; ex_data1/ex_data2 out 32; ex_imm out 32; ex_dest out TAG_W.

Function
REQ-011 SHALL buffer decoded instructions in a DEPTH-entry circular FIFO; enqueue when id_valid && id_ready && rdy_in.
REQ-012 SHALL drive id_ready = (count < DEPTH); no full-bypass: a full queue refuses enqueue even while dispatching.
REQ-013 SHALL allow simultaneous enqueue and dispatch when not full; count unchanged.
REQ-014 SHALL classify head: loads/stores -> LSB; ALU, ALU-imm, branch, jal, jalr, lui, auipc -> RS; unknown opcodes -> dropped (dequeued, no outputs).
REQ-015 SHALL dispatch head when valid && rdy_in && !clear && rob_ready && target ready; one instruction per cycle max.
REQ-016 SHALL drive rf_rs*_addr combinationally from head rs1/rs2.
REQ-017 SHALL form operands: rs1/rs2 from regfile; imm-ALU/jalr: op2 = imm, ready; jal: op1 = pc, op2 = 4; lui: op1 = 0, op2 = imm; auipc: op1 = pc, op2 = imm; lui/auipc/jal op1 ready.
REQ-018 SHALL, for a busy operand whose tag matches any valid CDB channel in the dispatch cycle, output busy=0 with that channel's data; lowest channel index wins on duplicate tags.
REQ-019 SHALL assert rf_rename_en in the dispatch cycle (rename_addr = rd, rename_tag = rob_free_tag) for rd-writing ops with rd != 0; never for stores/branches.
REQ-020 SHALL register all ROB/RS/LSB outputs; valids pulse one cycle; ex_dest = rob_free_tag captured.
REQ-021 SHALL give enqueue-to-output latency of 2 cycles on an empty queue with all readies high.
REQ-022 SHALL make pointers wrap modulo DEPTH.
REQ-023 SHALL, on clear, empty the FIFO at the next edge, suppress dispatch and rename that cycle, and drive all output valids 0 next cycle; clear beats enqueue.
REQ-024 SHALL, with rdy_in low, hold FIFO/pointers, drive rf_rename_en 0, and clear output valid registers.

Reset
REQ-025 SHALL, on rst_in low, asynchronously make count/pointers 0, all valid outputs 0, and data outputs 0.
REQ-026 SHALL resume normal operation on the first clk_in edge after rst_in high; reset mid-dispatch discards the in-flight instruction.

Structure
REQ-027 SHALL take opcode encodings, the unit-class enum, and the default TAG_W from the shared definitions package.
REQ-028 SHALL place class and operand-form decode in a combinational sub-module op_classify.

Verification
REQ-029 SHALL verify addi x1,x0,5 on an empty queue -> rs_valid at cycle +2 with ex_data2=5, ex_busy2=0, and rename x1->rob_free_tag.
REQ-030 SHALL verify DEPTH=4 with rs_ready=0 and 5 pushes -> id_ready=0 after the 4th; rs_ready=1 -> FIFO order preserved.
REQ-031 SHALL verify rf_busy1=1, tag 3, and cdb channel1 tag 3 data 0x77 in the dispatch cycle -> ex_busy1=0, ex_data1=0x77.
REQ-032 SHALL verify sw with lsb_ready=0 stalls and an rs-class instruction behind it is not dispatched (in-order); no rename asserted.
REQ-033 SHALL verify clear with 3 queued entries -> count 0 and no valids next cycle; a concurrent id_valid push is discarded.
REQ-034 SHALL verify rst_in low mid-dispatch -> all valids 0 immediately, without waiting for a clock.
